// File: rtl/cv32e40p_pkg.sv
// ----------------------------------------------------------------
// cv32e40p_pkg -- ALU opcodes and divider FSM state encoding
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package cv32e40p_pkg;

  localparam int unsigned ALU_OP_WIDTH = 7;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 7'b0011000,
    ALU_SUB  = 7'b0011001,
    ALU_XOR  = 7'b0101111,
    ALU_DIVU = 7'b0110000,
    ALU_DIV  = 7'b0110001,
    ALU_REMU = 7'b0110010,
    ALU_REM  = 7'b0110011
  } alu_opcode_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input alu_opcode_e op);
    return op inside {ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_div_abs.sv
// ----------------------------------------------------------------
// alu_div_abs -- conditional two's-complement negate
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module alu_div_abs
  import cv32e40p_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/alu_div_seq.sv
// ----------------------------------------------------------------
// alu_div_seq -- sequential restoring divider, one quotient bit per cycle
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module alu_div_seq
  import cv32e40p_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             core_clk,
  input  logic             rst,
  input  logic             enable_i,
  input  alu_opcode_e      operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             ex_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic             rem_sel_q, rem_sel_d;
  logic             special_q, special_d;

  logic             op_signed, op_rem, sgn_a, sgn_b, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, rem_after, quo_step, res_fix;
  logic [WIDTH:0]   diff;
  logic             q_bit;

  assign op_signed = operator_i[0];
  assign op_rem    = operator_i[1];
  assign sgn_a     = op_signed & operand_a_i[WIDTH-1];
  assign sgn_b     = op_signed & operand_b_i[WIDTH-1];
  assign div_zero  = (operand_b_i == '0);
  assign ovf       = op_signed && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                     && (operand_b_i == '1);

  alu_div_abs #(.WIDTH(WIDTH)) u_abs_a (.val_i(operand_a_i), .neg_i(sgn_a), .val_o(a_mag));
  alu_div_abs #(.WIDTH(WIDTH)) u_abs_b (.val_i(operand_b_i), .neg_i(sgn_b), .val_o(b_mag));

  // rem_q already holds the shifted partial remainder, so the borrow bit of
  // one subtraction decides the quotient bit.
  assign diff      = rem_q - {1'b0, dvs_q};
  assign q_bit     = ~diff[WIDTH];
  assign rem_after = q_bit ? diff[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], q_bit};

  alu_div_abs #(.WIDTH(WIDTH)) u_res_fix (
    .val_i(rem_sel_q ? rem_after : quo_step),
    .neg_i(neg_q),
    .val_o(res_fix)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    neg_d     = neg_q;
    rem_sel_d = rem_sel_q;
    special_d = special_q;
    case (state_q)
      DIV_IDLE: begin
        if (enable_i && is_div_op(operator_i)) begin
          state_d   = DIV_BUSY;
          cnt_d     = CNT_W'(WIDTH - 1);
          rem_d     = {{WIDTH{1'b0}}, a_mag[WIDTH-1]};
          quo_d     = {a_mag[WIDTH-2:0], 1'b0};
          dvs_d     = b_mag;
          rem_sel_d = op_rem;
          neg_d     = op_rem ? sgn_a : (sgn_a ^ sgn_b);
          special_d = div_zero | ovf;
          // Early-exit results are final at acceptance and only wait one cycle.
          if (div_zero)
            res_d = op_rem ? operand_a_i : '1;
          else if (ovf)
            res_d = op_rem ? '0 : operand_a_i;
          else
            res_d = '0;
        end
      end
      DIV_BUSY: begin
        if (special_q) begin
          state_d = DIV_DONE;
        end else begin
          rem_d = {rem_after, quo_q[WIDTH-1]};
          quo_d = quo_step;
          if (cnt_q == '0) begin
            state_d = DIV_DONE;
            res_d   = res_fix;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DIV_DONE: begin
        if (ex_ready_i)
          state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      rem_sel_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      neg_q     <= neg_d;
      rem_sel_q <= rem_sel_d;
      special_q <= special_d;
    end
  end

  assign ready_o  = (state_q == DIV_DONE);
  assign busy_o   = (state_q != DIV_IDLE);
  assign result_o = ready_o ? res_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_alu_div_seq.sv
// ----------------------------------------------------------------
// tb_alu_div_seq -- directed self-checking bench, 32- and 8-bit dividers
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_alu_div_seq;
  import cv32e40p_pkg::*;

  logic core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic        rst;
  logic        en, exr;
  alu_opcode_e op;
  logic [31:0] a, b, res;
  logic        rdy, bsy;

  logic        en8, exr8;
  alu_opcode_e op8;
  logic [7:0]  a8, b8, res8;
  logic        rdy8, bsy8;

  int checks = 0;
  int errors = 0;

  alu_div_seq #(.WIDTH(32)) u_dut32 (
    .core_clk(core_clk), .rst(rst), .enable_i(en), .operator_i(op),
    .operand_a_i(a), .operand_b_i(b), .ex_ready_i(exr),
    .result_o(res), .ready_o(rdy), .busy_o(bsy)
  );

  alu_div_seq #(.WIDTH(8)) u_dut8 (
    .core_clk(core_clk), .rst(rst), .enable_i(en8), .operator_i(op8),
    .operand_a_i(a8), .operand_b_i(b8), .ex_ready_i(exr8),
    .result_o(res8), .ready_o(rdy8), .busy_o(bsy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run32(input string tag, input alu_opcode_e o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input int exp_lat, input int hold);
    int n;
    @(negedge core_clk);
    en = 1'b1; op = o; a = x; b = y; exr = 1'b0;
    @(posedge core_clk); #1;
    // Scramble inputs right after acceptance; the operation must not notice.
    en = 1'b0; op = ALU_REM; a = $urandom; b = $urandom;
    check({tag, " busy"}, 32'(bsy), 32'd1);
    check({tag, " res0"}, res, 32'd0);
    n = 0;
    while (!rdy && n < 200) begin
      @(posedge core_clk); #1;
      n++;
    end
    check({tag, " lat"}, 32'(n), 32'(exp_lat));
    check({tag, " res"}, res, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(posedge core_clk); #1;
      check({tag, " hold rdy"}, 32'(rdy), 32'd1);
      check({tag, " hold res"}, res, exp_res);
    end
    @(negedge core_clk);
    exr = 1'b1;
    @(posedge core_clk); #1;
    exr = 1'b0;
    check({tag, " idle"}, {res[29:0], rdy, bsy}, 32'd0);
  endtask

  task automatic run8(input string tag, input alu_opcode_e o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] exp_res, input int exp_lat);
    int n;
    @(negedge core_clk);
    en8 = 1'b1; op8 = o; a8 = x; b8 = y; exr8 = 1'b0;
    @(posedge core_clk); #1;
    en8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!rdy8 && n < 50) begin
      @(posedge core_clk); #1;
      n++;
    end
    check({tag, " lat"}, 32'(n), 32'(exp_lat));
    check({tag, " res"}, {24'd0, res8}, {24'd0, exp_res});
    @(negedge core_clk);
    exr8 = 1'b1;
    @(posedge core_clk); #1;
    exr8 = 1'b0;
    check({tag, " idle"}, {22'd0, res8, rdy8, bsy8}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; exr = 1'b0; op = ALU_ADD; a = '0; b = '0;
    en8 = 1'b0; exr8 = 1'b0; op8 = ALU_ADD; a8 = '0; b8 = '0;
    repeat (3) @(posedge core_clk);
    #1;
    check("reset 32", {res[29:0], rdy, bsy}, 32'd0);
    check("reset 8", {22'd0, res8, rdy8, bsy8}, 32'd0);
    @(negedge core_clk);
    rst = 1'b0;

    @(negedge core_clk);
    en = 1'b1; op = ALU_ADD; a = 32'd100; b = 32'd7;
    @(posedge core_clk); #1;
    en = 1'b0;
    check("ignored op", 32'(bsy), 32'd0);

    run32("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
    run32("remu 100/7", ALU_REMU, 32'd100, 32'd7, 32'd2, 32, 0);
    run32("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0);
    run32("rem -7/2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0);
    run32("div 100/-7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32, 0);
    run32("rem -100/7", ALU_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32, 0);
    run32("rem 100/-7", ALU_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 32, 0);
    run32("divu max/1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, 0);
    run32("divu 5/0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run32("remu 5/0", ALU_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
    run32("div -7/0", ALU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run32("rem -7/0", ALU_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
    run32("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run32("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run32("divu 8..0/max", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32, 0);
    run32("remu 8..0/max", ALU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0);
    run32("hold divu", ALU_DIVU, 32'd1000, 32'd10, 32'd100, 32, 5);

    // Request alongside ex_ready in DONE must be dropped.
    @(negedge core_clk);
    en = 1'b1; op = ALU_DIVU; a = 32'd5; b = 32'd0;
    @(posedge core_clk); #1;
    en = 1'b0;
    @(posedge core_clk); #1;
    check("done rdy", 32'(rdy), 32'd1);
    @(negedge core_clk);
    en = 1'b1; exr = 1'b1;
    @(posedge core_clk); #1;
    en = 1'b0; exr = 1'b0;
    check("done req dropped", {rdy, bsy}, 32'd0);
    @(posedge core_clk); #1;
    check("still idle", 32'(bsy), 32'd0);

    // Reset during the 10th BUSY cycle.
    @(negedge core_clk);
    en = 1'b1; op = ALU_DIVU; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge core_clk); #1;
    en = 1'b0;
    repeat (9) @(posedge core_clk);
    @(negedge core_clk);
    rst = 1'b1;
    @(posedge core_clk); #1;
    rst = 1'b0;
    check("mid-busy reset", {res[29:0], rdy, bsy}, 32'd0);
    run32("divu 9/3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 32, 0);

    // Request during reset is dropped; first edge with rst low accepts it.
    @(negedge core_clk);
    rst = 1'b1; en = 1'b1; op = ALU_DIVU; a = 32'd20; b = 32'd4;
    @(posedge core_clk); #1;
    check("req in reset", 32'(bsy), 32'd0);
    rst = 1'b0;
    run32("divu 20/4", ALU_DIVU, 32'd20, 32'd4, 32'd5, 32, 0);

    run8("w8 divu 200/3", ALU_DIVU, 8'd200, 8'd3, 8'd66, 8);
    run8("w8 remu 200/3", ALU_REMU, 8'd200, 8'd3, 8'd2, 8);
    run8("w8 rem ovf", ALU_REM, 8'h80, 8'hFF, 8'h00, 1);
    run8("w8 div ovf", ALU_DIV, 8'h80, 8'hFF, 8'h80, 1);
    run8("w8 div -7/2", ALU_DIV, 8'hF9, 8'd2, 8'hFD, 8);
    run8("w8 divu 7/0", ALU_DIVU, 8'd7, 8'd0, 8'hFF, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_div_seq.md
ALU_DIV_SEQ -- requirements
Module: alu_div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be at least 4.
REQ-002 core_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high; SHALL be sampled only on core_clk rising edge.
REQ-004 enable_i  in  1  request a division; sampled only in IDLE.
REQ-005 operator_i  in  ALU_OP_WIDTH  alu_opcode_e; accepted values ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM (bit0 = signed, bit1 = remainder).
REQ-006 operand_a_i  in  WIDTH  dividend.
REQ-007 operand_b_i  in  WIDTH  divisor.
REQ-008 ex_ready_i  in  1  EX stage consumes the result.
REQ-009 result_o  out  WIDTH  quotient or remainder; valid only while ready_o=1.
REQ-010 ready_o  out  1  result valid; high only in DONE.
REQ-011 busy_o  out  1  high in BUSY and DONE.

Function
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 IDLE->BUSY when enable_i=1 and operator_i is a div/rem opcode; operands and opcode captured on that edge (acceptance edge).
REQ-014 enable_i with any other opcode SHALL be ignored; FSM stays IDLE.
REQ-015 Input changes after acceptance SHALL NOT affect the operation in flight.
REQ-016 Algorithm: restoring division on magnitudes, one quotient bit per cycle, MSB first, WIDTH-bit iteration counter.
REQ-017 Signed ops: magnitudes of both operands; quotient negated when signs differ; remainder takes dividend's sign.
REQ-018 Normal latency: BUSY for WIDTH edges; ready_o SHALL rise on the WIDTH-th edge after acceptance.
REQ-019 Divisor zero: quotient = all ones, remainder = dividend; FSM SHALL go BUSY->DONE on the first edge after acceptance.
REQ-020 Signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor = all ones, signed op): quotient = dividend, remainder = 0; same 1-cycle latency as REQ-019.
REQ-021 DONE holds result_o and ready_o stable until ex_ready_i=1, then DONE->IDLE on that edge.
REQ-022 enable_i in the DONE cycle with ex_ready_i=1 SHALL NOT be accepted; a new request is accepted no earlier than the next IDLE cycle.
REQ-023 result_o SHALL be 0 whenever ready_o=0.
REQ-024 All arithmetic SHALL be WIDTH bits with no truncation error; the partial remainder register SHALL be WIDTH+1 bits.

Reset
REQ-025 rst=1 SHALL force IDLE, ready_o=0, busy_o=0, result_o=0, counter=0 on the same edge, including mid-BUSY or in DONE.
REQ-026 A request presented in the same cycle as rst=1 SHALL be dropped.
REQ-027 The first request SHALL be accepted on the first edge with rst=0.

Structure
REQ-028 alu_opcode_e and ALU_OP_WIDTH SHALL come from cv32e40p_pkg; new FSM state typedef div_state_e SHALL be added to that package.
REQ-029 One sub-module, alu_div_abs (WIDTH-parametrised combinational conditional two's-complement negate), SHALL be used for operand magnitude and result sign fix.
REQ-030 No latches; single always_ff for state, counter and datapath registers.

Verification
REQ-031 WIDTH=32, DIVU 100/7 -> result 14, ready_o on the 32nd edge after acceptance; REMU 100/7 -> 2.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-033 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with ready_o on the 1st edge; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 ex_ready_i=0 for 5 cycles in DONE -> result_o stable, ready_o=1 throughout; ex_ready_i=1 -> IDLE on the next edge.
REQ-035 rst=1 on the 10th BUSY cycle -> IDLE, all outputs 0 on that edge; a new DIVU 9/3 then returns 3.
REQ-036 WIDTH=8, DIVU 200/3 -> 66 after 8 cycles; REM 0x80 / 0xFF -> 0.
